colour_blob_tracker: RTL and testbench

- Pixel-stream stage between the Video_In decoder and vga_adapter. Consumes the decoded RGB565 stream (x, y, red, green, blue, pixel_en).
- Classifies each pixel against a target-colour window. Drives a 3-bit overlay stream to the VGA adapter: matches painted green, crosshair at the last centroid.
- At each frame end, computes the centroid of matching pixels with a sequential divider and publishes it for the car-steering logic.

---
 rtl/blob_pkg.sv | 18 +
 rtl/seq_divider.sv | 75 +++++++
 rtl/colour_blob_tracker.sv | 182 ++++++++++++++++++
 tb/tb_colour_blob_tracker.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/blob_pkg.sv
// rtl/blob_pkg.sv - shared widths, overlay colours and FSM states for the blob tracker
package blob_pkg;

    localparam int SUM_W = 25;
    localparam int CNT_W = 17;
    localparam int X_W   = 9;
    localparam int Y_W   = 8;

    localparam logic [2:0] OVERLAY_MATCH = 3'b010;
    localparam logic [2:0] OVERLAY_CROSS = 3'b111;

    typedef enum logic [1:0] {
        IDLE,
        DIV,
        PUBLISH
    } blob_state_t;

endpackage

// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - unsigned restoring divider, one quotient bit per cycle
//
// Ports:
//   clock, resetn      clock and asynchronous active-low reset
//   start              load dividend/divisor and begin (ignored while busy)
//   dividend, divisor  operands, sampled on the start cycle
//   busy               division in progress
//   done               one-cycle pulse once the quotient is final
//   quotient           low QW bits of the quotient, held until the next start
module seq_divider #(
    parameter int NW = 25,
    parameter int DW = 17,
    parameter int QW = 9
) (
    input  logic          clock,
    input  logic          resetn,
    input  logic          start,
    input  logic [NW-1:0] dividend,
    input  logic [DW-1:0] divisor,
    output logic          busy,
    output logic          done,
    output logic [QW-1:0] quotient
);

    localparam int CW = $clog2(NW + 1);

    logic [DW-1:0] rem, den, src_rem, src_den, nxt_rem;
    logic [NW-1:0] quo, src_quo, nxt_quo;
    logic [DW:0]   rem_sh;
    logic          fits;
    logic [CW-1:0] steps;

    // The start cycle already performs the first step on the raw operands,
    // so NW steps finish NW-1 cycles after start.
    always_comb begin
        src_rem = busy ? rem : '0;
        src_quo = busy ? quo : dividend;
        src_den = busy ? den : divisor;
        rem_sh  = {src_rem, src_quo[NW-1]};
        fits    = rem_sh >= {1'b0, src_den};
        nxt_rem = fits ? DW'(rem_sh - {1'b0, src_den}) : rem_sh[DW-1:0];
        nxt_quo = {src_quo[NW-2:0], fits};
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            rem   <= '0;
            den   <= '0;
            quo   <= '0;
            steps <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            if (busy) begin
                rem   <= nxt_rem;
                quo   <= nxt_quo;
                steps <= steps - 1'b1;
                if (steps == CW'(1)) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
            end else if (start) begin
                rem   <= nxt_rem;
                quo   <= nxt_quo;
                den   <= divisor;
                steps <= CW'(NW - 1);
                busy  <= 1'b1;
            end
        end
    end

    assign quotient = quo[QW-1:0];

endmodule

// File: rtl/colour_blob_tracker.sv
// rtl/colour_blob_tracker.sv - colour-window pixel classifier, overlay stream and frame centroid
//
// Ports:
//   clock, resetn                    clock and asynchronous active-low reset
//   x, y, red, green, blue, pixel_en decoded RGB565 pixel stream
//   out_x, out_y, out_colour, out_plot  overlay stream, one cycle behind the input
//   centroid_x, centroid_y, centroid_valid, match_count  last published frame result
//   frame_done                       pulse when a result is published
//   frame_dropped                    pulse when a frame end arrives while still busy
module colour_blob_tracker
    import blob_pkg::*;
#(
    parameter logic [4:0]       R_MIN      = 5'd20,
    parameter logic [5:0]       G_MAX      = 6'd24,
    parameter logic [4:0]       B_MAX      = 5'd12,
    parameter logic [CNT_W-1:0] MIN_PIXELS = 17'd64,
    parameter logic [X_W-1:0]   X_LAST     = 9'd319,
    parameter logic [Y_W-1:0]   Y_LAST     = 8'd239
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic [X_W-1:0]   x,
    input  logic [Y_W-1:0]   y,
    input  logic [4:0]       red,
    input  logic [5:0]       green,
    input  logic [4:0]       blue,
    input  logic             pixel_en,
    output logic [X_W-1:0]   out_x,
    output logic [Y_W-1:0]   out_y,
    output logic [2:0]       out_colour,
    output logic             out_plot,
    output logic [X_W-1:0]   centroid_x,
    output logic [Y_W-1:0]   centroid_y,
    output logic             centroid_valid,
    output logic [CNT_W-1:0] match_count,
    output logic             frame_done,
    output logic             frame_dropped
);

    blob_state_t      state, state_nxt;
    logic             match, frame_end, div_start, take_snap, drop;
    logic             x_busy, y_busy, x_done, y_done, div_busy;
    logic [SUM_W-1:0] sum_x, sum_y, sum_x_nxt, sum_y_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt, snap_cnt;
    logic [X_W-1:0]   qx;
    logic [Y_W-1:0]   qy;
    logic [2:0]       colour_nxt;

    assign match     = pixel_en && (red >= R_MIN) && (green <= G_MAX) && (blue <= B_MAX);
    assign frame_end = pixel_en && (x == X_LAST) && (y == Y_LAST);
    assign div_busy  = x_busy | y_busy;

    // The *_nxt values include the current pixel, so the frame-end pixel
    // lands in the snapshot handed to the dividers.
    assign sum_x_nxt = sum_x + (match ? {{(SUM_W-X_W){1'b0}}, x} : '0);
    assign sum_y_nxt = sum_y + (match ? {{(SUM_W-Y_W){1'b0}}, y} : '0);
    assign cnt_nxt   = cnt + {{(CNT_W-1){1'b0}}, match};

    always_comb begin
        colour_nxt = {red[4], green[5], blue[4]};
        if (centroid_valid && (x == centroid_x || y == centroid_y))
            colour_nxt = OVERLAY_CROSS;
        else if (match)
            colour_nxt = OVERLAY_MATCH;
    end

    always_comb begin
        state_nxt = state;
        div_start = 1'b0;
        take_snap = 1'b0;
        drop      = 1'b0;
        case (state)
            IDLE: begin
                if (frame_end) begin
                    // A divider that cannot accept a start means the frame is lost.
                    if (div_busy) begin
                        drop = 1'b1;
                    end else begin
                        take_snap = 1'b1;
                        if (cnt_nxt < MIN_PIXELS) begin
                            state_nxt = PUBLISH;
                        end else begin
                            div_start = 1'b1;
                            state_nxt = DIV;
                        end
                    end
                end
            end
            DIV: begin
                drop = frame_end;
                if (x_done && y_done)
                    state_nxt = PUBLISH;
            end
            PUBLISH: begin
                drop      = frame_end;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    seq_divider #(.NW(SUM_W), .DW(CNT_W), .QW(X_W)) u_div_x (
        .clock    (clock),
        .resetn   (resetn),
        .start    (div_start),
        .dividend (sum_x_nxt),
        .divisor  (cnt_nxt),
        .busy     (x_busy),
        .done     (x_done),
        .quotient (qx)
    );

    seq_divider #(.NW(SUM_W), .DW(CNT_W), .QW(Y_W)) u_div_y (
        .clock    (clock),
        .resetn   (resetn),
        .start    (div_start),
        .dividend (sum_y_nxt),
        .divisor  (cnt_nxt),
        .busy     (y_busy),
        .done     (y_done),
        .quotient (qy)
    );

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            sum_x          <= '0;
            sum_y          <= '0;
            cnt            <= '0;
            snap_cnt       <= '0;
            out_x          <= '0;
            out_y          <= '0;
            out_colour     <= '0;
            out_plot       <= 1'b0;
            centroid_x     <= '0;
            centroid_y     <= '0;
            centroid_valid <= 1'b0;
            match_count    <= '0;
            frame_done     <= 1'b0;
            frame_dropped  <= 1'b0;
        end else begin
            if (frame_end) begin
                sum_x <= '0;
                sum_y <= '0;
                cnt   <= '0;
            end else begin
                sum_x <= sum_x_nxt;
                sum_y <= sum_y_nxt;
                cnt   <= cnt_nxt;
            end
            if (take_snap)
                snap_cnt <= cnt_nxt;

            out_plot <= pixel_en;
            if (pixel_en) begin
                out_x      <= x;
                out_y      <= y;
                out_colour <= colour_nxt;
            end

            frame_done    <= (state == PUBLISH);
            frame_dropped <= drop;
            if (state == PUBLISH) begin
                match_count <= snap_cnt;
                if (snap_cnt >= MIN_PIXELS) begin
                    centroid_x     <= qx;
                    centroid_y     <= qy;
                    centroid_valid <= 1'b1;
                end else begin
                    centroid_valid <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_colour_blob_tracker.sv
// tb/tb_colour_blob_tracker.sv - self-checking bench for colour_blob_tracker
module tb_colour_blob_tracker;

    logic        clock = 1'b0;
    logic        resetn;
    logic [8:0]  x;
    logic [7:0]  y;
    logic [4:0]  red;
    logic [5:0]  green;
    logic [4:0]  blue;
    logic        pixel_en;

    logic [8:0]  o_x [2];
    logic [7:0]  o_y [2];
    logic [2:0]  o_col [2];
    logic        o_plot [2];
    logic [8:0]  c_x [2];
    logic [7:0]  c_y [2];
    logic        c_v [2];
    logic [16:0] m_cnt [2];
    logic        f_done [2];
    logic        f_drop [2];

    always #5 clock = ~clock;

    colour_blob_tracker dut0 (
        .clock(clock), .resetn(resetn), .x(x), .y(y), .red(red), .green(green),
        .blue(blue), .pixel_en(pixel_en), .out_x(o_x[0]), .out_y(o_y[0]),
        .out_colour(o_col[0]), .out_plot(o_plot[0]), .centroid_x(c_x[0]),
        .centroid_y(c_y[0]), .centroid_valid(c_v[0]), .match_count(m_cnt[0]),
        .frame_done(f_done[0]), .frame_dropped(f_drop[0])
    );

    colour_blob_tracker #(.MIN_PIXELS(17'd1)) dut1 (
        .clock(clock), .resetn(resetn), .x(x), .y(y), .red(red), .green(green),
        .blue(blue), .pixel_en(pixel_en), .out_x(o_x[1]), .out_y(o_y[1]),
        .out_colour(o_col[1]), .out_plot(o_plot[1]), .centroid_x(c_x[1]),
        .centroid_y(c_y[1]), .centroid_valid(c_v[1]), .match_count(m_cnt[1]),
        .frame_done(f_done[1]), .frame_dropped(f_drop[1])
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(string name, int inst, int unsigned act, int unsigned exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s dut%0d t=%0t actual=%0d required=%0d", name, inst, $time, act, exp);
        end
    endtask

    // Behavioural model: frame statistics, division by '/', spec latencies.
    int unsigned min_px [2] = '{64, 1};
    int unsigned ax [2], ay [2], ac [2], sx [2], sy [2], sc [2];
    int unsigned mcx [2], mcy [2], mcnt [2], mcv [2];
    int unsigned e_x [2], e_y [2], e_col [2], e_plot [2], e_done [2], e_drop [2];
    bit          pend [2];
    int          pub_edge [2];
    int          edge_k = 0;

    function automatic void model_step(int i);
        bit m, fe;
        if (!resetn) begin
            ax[i] = 0; ay[i] = 0; ac[i] = 0; pend[i] = 0;
            mcx[i] = 0; mcy[i] = 0; mcnt[i] = 0; mcv[i] = 0;
            e_x[i] = 0; e_y[i] = 0; e_col[i] = 0; e_plot[i] = 0; e_done[i] = 0; e_drop[i] = 0;
            return;
        end
        m  = pixel_en && red >= 20 && green <= 24 && blue <= 12;
        fe = pixel_en && x == 319 && y == 239;
        e_plot[i] = pixel_en;
        e_done[i] = 0;
        e_drop[i] = 0;
        if (pixel_en) begin
            e_x[i] = x;
            e_y[i] = y;
            if (mcv[i] != 0 && (x == mcx[i] || y == mcy[i])) e_col[i] = 7;
            else if (m) e_col[i] = 2;
            else e_col[i] = {red[4], green[5], blue[4]};
        end
        if (m) begin
            ax[i] += x; ay[i] += y; ac[i] += 1;
        end
        if (fe) begin
            if (pend[i]) begin
                e_drop[i] = 1;
            end else begin
                sx[i] = ax[i]; sy[i] = ay[i]; sc[i] = ac[i];
                pend[i] = 1;
                pub_edge[i] = edge_k + ((ac[i] >= min_px[i]) ? 26 : 1);
            end
            ax[i] = 0; ay[i] = 0; ac[i] = 0;
        end
        if (pend[i] && edge_k == pub_edge[i]) begin
            e_done[i] = 1;
            mcnt[i] = sc[i];
            if (sc[i] >= min_px[i]) begin
                mcx[i] = sx[i] / sc[i];
                mcy[i] = sy[i] / sc[i];
                mcv[i] = 1;
            end else begin
                mcv[i] = 0;
            end
            pend[i] = 0;
        end
    endfunction

    always @(posedge clock) begin
        edge_k++;
        for (int i = 0; i < 2; i++) model_step(i);
        #1;
        for (int i = 0; i < 2; i++) begin
            chk("out_x", i, o_x[i], e_x[i]);
            chk("out_y", i, o_y[i], e_y[i]);
            chk("out_colour", i, o_col[i], e_col[i]);
            chk("out_plot", i, o_plot[i], e_plot[i]);
            chk("centroid_x", i, c_x[i], mcx[i]);
            chk("centroid_y", i, c_y[i], mcy[i]);
            chk("centroid_valid", i, c_v[i], mcv[i]);
            chk("match_count", i, m_cnt[i], mcnt[i]);
            chk("frame_done", i, f_done[i], e_done[i]);
            chk("frame_dropped", i, f_drop[i], e_drop[i]);
        end
    end

    task automatic px(int xx, int yy, int r, int g, int b);
        @(negedge clock);
        x = 9'(xx); y = 8'(yy); red = 5'(r); green = 6'(g); blue = 5'(b);
        pixel_en = 1'b1;
    endtask

    task automatic gap(int n);
        repeat (n) begin
            @(negedge clock);
            pixel_en = 1'b0;
        end
    endtask

    task automatic wait_done(int i, int exp_lat, string name);
        int lat = 0;
        while (lat < 60) begin
            @(negedge clock);
            pixel_en = 1'b0;
            lat++;
            if (f_done[i]) break;
        end
        chk(name, i, lat, exp_lat);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        int nd, lat_e, ndrop;
        resetn = 1'b0; pixel_en = 1'b0;
        x = '0; y = '0; red = '0; green = '0; blue = '0;
        repeat (3) @(negedge clock);
        chk("rst out_plot", 0, o_plot[0], 0);
        chk("rst match_count", 0, m_cnt[0], 0);
        chk("rst frame_done", 0, f_done[0], 0);
        resetn = 1'b1;

        // Reset asserted between edges while dividing.
        for (int i = 0; i < 70; i++) px(i, 3, 31, 0, 0);
        px(319, 239, 0, 0, 0);
        gap(5);
        #2 resetn = 1'b0;
        #1;
        chk("async rst out_x", 0, o_x[0], 0);
        chk("async rst out_y", 0, o_y[0], 0);
        chk("async rst out_colour", 1, o_col[1], 0);
        @(negedge clock);
        resetn = 1'b1;
        nd = 0;
        repeat (40) begin
            @(negedge clock);
            if (f_done[0] || f_done[1]) nd++;
        end
        chk("no done after abort", 0, nd, 0);

        // Full frame with a 10x10 red block.
        for (int yy = 0; yy < 240; yy++) begin
            for (int xx = 0; xx < 320; xx++) begin
                px(xx, yy, (xx >= 100 && xx <= 109 && yy >= 50 && yy <= 59) ? 31 : 0, 0, 0);
                if (yy == 50 && xx == 101) begin
                    chk("block out_x", 0, o_x[0], 100);
                    chk("block colour", 0, o_col[0], 2);
                end
                if (yy == 50 && xx == 111) chk("past block colour", 0, o_col[0], 0);
            end
        end
        wait_done(0, 27, "block latency");
        chk("block match_count", 0, m_cnt[0], 100);
        chk("block centroid_x", 0, c_x[0], 104);
        chk("block centroid_y", 0, c_y[0], 54);
        chk("block valid", 0, c_v[0], 1);
        gap(10);

        // Black frame: crosshair at (104,54), plus match-window boundary pixels.
        for (int yy = 52; yy <= 56; yy++) begin
            for (int xx = 0; xx < 320; xx++) begin
                px(xx, yy, 0, 0, 0);
                if (yy == 53 && xx == 105) chk("cross col", 0, o_col[0], 7);
                if (yy == 53 && xx == 106) chk("beside cross", 0, o_col[0], 0);
                if (yy == 54 && xx == 10) chk("cross row", 0, o_col[0], 7);
            end
        end
        for (int yy = 0; yy < 240; yy += 7) begin
            px(104, yy, 0, 0, 0);
            px(103, yy, 0, 0, 0);
        end
        px(10, 10, 20, 24, 12);
        px(11, 10, 19, 0, 0);
        chk("edge match colour", 0, o_col[0], 2);
        px(12, 10, 31, 25, 0);
        chk("red19 colour", 0, o_col[0], 4);
        px(13, 10, 31, 0, 13);
        px(319, 239, 0, 0, 0);
        wait_done(0, 2, "sparse latency");
        chk("sparse match_count", 0, m_cnt[0], 1);
        chk("sparse valid", 0, c_v[0], 0);
        chk("sparse held x", 0, c_x[0], 104);
        gap(10);

        // 63 matches: one short of a valid centroid.
        for (int i = 0; i < 63; i++) px(200 + i, 100, 31, 0, 0);
        px(319, 239, 0, 0, 0);
        wait_done(0, 2, "63 latency");
        chk("63 match_count", 0, m_cnt[0], 63);
        chk("63 valid", 0, c_v[0], 0);
        chk("63 held x", 0, c_x[0], 104);
        chk("63 held y", 0, c_y[0], 54);
        gap(40);

        // Only the final pixel matches; MIN_PIXELS=1 instance.
        px(319, 239, 31, 0, 0);
        wait_done(1, 27, "last px latency");
        chk("last px x", 1, c_x[1], 319);
        chk("last px y", 1, c_y[1], 239);
        chk("last px count", 1, m_cnt[1], 1);
        chk("last px valid", 1, c_v[1], 1);
        gap(40);

        // Second frame end 10 cycles after the first.
        for (int i = 0; i < 64; i++) px(i, 10, 31, 0, 0);
        px(319, 239, 0, 0, 0);
        lat_e = 0; ndrop = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clock);
            if (f_done[0] && lat_e == 0) lat_e = k;
            if (f_drop[0]) ndrop++;
            if (k == 3) begin
                x = 9'd5; y = 8'd5; red = 5'd31; green = '0; blue = '0; pixel_en = 1'b1;
            end else if (k == 10) begin
                x = 9'd319; y = 8'd239; red = 5'd31; green = '0; blue = '0; pixel_en = 1'b1;
            end else begin
                pixel_en = 1'b0;
            end
        end
        chk("drop first latency", 0, lat_e, 27);
        chk("drop pulses", 0, ndrop, 1);
        chk("drop first x", 0, c_x[0], 31);
        chk("drop first y", 0, c_y[0], 10);
        chk("drop first count", 0, m_cnt[0], 64);

        for (int i = 0; i < 64; i++) px(i, 20, 31, 0, 0);
        px(319, 239, 0, 0, 0);
        wait_done(0, 27, "restart latency");
        chk("restart count", 0, m_cnt[0], 64);
        chk("restart x", 0, c_x[0], 31);
        chk("restart y", 0, c_y[0], 20);
        gap(5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
